// File: rtl/game_pkg.sv
// Shared constants for the whack-a-mole game: mole/LED width, default RNG
// seed and the LFSR feedback tap mask.
package game_pkg;
    localparam int          MOLE_W           = 8;
    localparam logic [7:0]  RNG_SEED_DEFAULT = 8'hA5;
    // Taps for x^8+x^6+x^5+x^4+1: feedback = q[7]^q[5]^q[4]^q[3].
    localparam logic [7:0]  LFSR_TAPS        = 8'hB8;
endpackage

// File: rtl/rng_lfsr.sv
// Fibonacci LFSR register with a load-on-reset seed and an advance enable.
// A zero state (which a maximal-length LFSR can only reach through an upset)
// is steered back to 1 on the next advance so the generator cannot lock up.
module rng_lfsr
    import game_pkg::*;
#(
    parameter int               WIDTH = MOLE_W,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    output logic [WIDTH-1:0] q
);

    logic             fb;
    logic [WIDTH-1:0] next_q;

    // Next-state: shift left, feedback into bit 0; zero state escapes to 1.
    always_comb begin
        fb     = ^(q & TAPS);
        next_q = {q[WIDTH-2:0], fb};
        if (q == '0) begin
            next_q = {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // State register: reset load dominates any advance on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= seed;
        end else if (enable) begin
            q <= next_q;
        end
    end

endmodule

// File: rtl/rng.sv
// 8-bit pseudo-random pattern source for the mole LEDs. Wraps rng_lfsr with a
// hold counter so the pattern advances once every HOLD_CYCLES clocks, and
// replaces an illegal all-zero seed with 1.
module rng
    import game_pkg::*;
#(
    parameter int               WIDTH       = MOLE_W,
    parameter logic [WIDTH-1:0] SEED        = RNG_SEED_DEFAULT,
    parameter int unsigned      HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] random_number
);

    // Counter just wide enough for 0..HOLD_CYCLES-1 (at least one bit).
    localparam int               CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [CNT_W-1:0] hold_cnt;
    logic             advance;

    assign advance = (hold_cnt == CNT_LAST);

    // Hold counter: clears on reset, wraps after the advancing cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (advance) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

    rng_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (WIDTH'(LFSR_TAPS))
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .seed   (SEED_EFF),
        .enable (advance),
        .q      (random_number)
    );

endmodule

// File: tb/tb_rng.sv
// Bench for rng: three instances (default, HOLD_CYCLES=4, zero seed) on one
// clock. The stimulus process drives reset at the falling edge and pushes the
// value expected after the next rising edge; a monitor pops and compares just
// after each rising edge.
module tb_rng;

  logic       clk;
  logic       rst_a, rst_b, rst_c;
  logic [7:0] rn_a, rn_b, rn_c;

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic [7:0] exp_q_c[$];

  int n_checks = 0;
  int n_fail   = 0;

  rng #(.HOLD_CYCLES(1)) dut_a (.clk(clk), .reset(rst_a), .random_number(rn_a));
  rng #(.HOLD_CYCLES(4)) dut_b (.clk(clk), .reset(rst_b), .random_number(rn_b));
  rng #(.SEED(8'h00), .HOLD_CYCLES(1)) dut_c (.clk(clk), .reset(rst_c), .random_number(rn_c));

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference next-state from the polynomial x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] model_next(input logic [7:0] s);
    logic b;
    if (s == 8'h00) return 8'h01;
    b = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], b};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: set reset of one instance, queue the value due after next edge
  task automatic step(input int d, input logic r, input logic [7:0] e);
    @(negedge clk);
    case (d)
      0: begin rst_a = r; exp_q_a.push_back(e); end
      1: begin rst_b = r; exp_q_b.push_back(e); end
      default: begin rst_c = r; exp_q_c.push_back(e); end
    endcase
  endtask

  // scoreboard monitor
  logic [7:0] mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q_a.size() > 0) begin mon_e = exp_q_a.pop_front(); check("seq_a", rn_a, mon_e); end
    if (exp_q_b.size() > 0) begin mon_e = exp_q_b.pop_front(); check("seq_b", rn_b, mon_e); end
    if (exp_q_c.size() > 0) begin mon_e = exp_q_c.pop_front(); check("seq_c", rn_c, mon_e); end
  end

  logic [7:0] m;
  logic [7:0] obs[600];
  bit         seen[256];
  int         cnt;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;

    // --- DUT a: reset value, sequence, mid-operation reset
    step(0, 1'b1, 8'hA5);
    step(0, 1'b1, 8'hA5);
    step(0, 1'b0, 8'h4A);
    step(0, 1'b0, 8'h95);
    step(0, 1'b0, 8'h2A);
    step(0, 1'b0, 8'h54);
    m = 8'h54;
    for (int i = 0; i < 6; i++) begin
      m = model_next(m);
      step(0, 1'b0, m);
    end
    step(0, 1'b1, 8'hA5);
    step(0, 1'b0, 8'h4A);
    step(0, 1'b0, 8'h95);

    // --- DUT a: period and no-zero over 600 advances
    step(0, 1'b1, 8'hA5);
    m = 8'hA5;
    for (int i = 0; i < 600; i++) begin
      m = model_next(m);
      step(0, 1'b0, m);
      @(posedge clk);
      #2;
      obs[i] = rn_a;
    end
    cnt = 0;
    for (int i = 0; i < 600; i++) if (obs[i] == 8'h00) cnt++;
    check("no_zero_cnt", 8'(cnt), 8'd0);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 255; i++) begin
      if (!seen[obs[i]] && obs[i] != 8'h00) cnt++;
      seen[obs[i]] = 1'b1;
    end
    check("distinct_in_period", 8'(cnt), 8'd255);
    check("seed_at_255", obs[254], 8'hA5);
    check("seed_at_510", obs[509], 8'hA5);
    cnt = 0;
    for (int i = 0; i < 509; i++) if (obs[i] == 8'hA5) cnt++;
    check("seed_recur_count", 8'(cnt), 8'd1);
    step(0, 1'b1, 8'hA5);

    // --- DUT b: HOLD_CYCLES = 4
    step(1, 1'b1, 8'hA5);
    step(1, 1'b1, 8'hA5);
    step(1, 1'b0, 8'hA5);
    step(1, 1'b0, 8'hA5);
    step(1, 1'b0, 8'hA5);
    step(1, 1'b0, 8'h4A);
    step(1, 1'b0, 8'h4A);
    step(1, 1'b0, 8'h4A);
    step(1, 1'b0, 8'h4A);
    step(1, 1'b0, 8'h95);
    step(1, 1'b0, 8'h95);
    step(1, 1'b0, 8'h95);
    step(1, 1'b0, 8'h95);
    step(1, 1'b0, 8'h2A);
    step(1, 1'b1, 8'hA5);
    step(1, 1'b0, 8'hA5);

    // --- DUT c: zero seed substituted with 1
    step(2, 1'b1, 8'h01);
    step(2, 1'b1, 8'h01);
    step(2, 1'b0, 8'h02);
    step(2, 1'b0, 8'h04);
    step(2, 1'b0, 8'h08);
    step(2, 1'b0, 8'h11);
    step(2, 1'b0, 8'h23);
    step(2, 1'b0, 8'h47);
    m = 8'h47;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      m = model_next(m);
      step(2, 1'b0, m);
      @(posedge clk);
      #2;
      if (rn_c == 8'h00) cnt++;
    end
    check("zero_seed_nonzero", 8'(cnt), 8'd0);

    // drain and report
    @(posedge clk);
    #3;
    check("queues_drained", 8'(exp_q_a.size() + exp_q_b.size() + exp_q_c.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
